alu_step_sequencer: RTL
=======================

# alu_step_sequencer

Button-driven sequencer for the 4-bit adder/subtractor and comparator datapath on the lab board. It walks the user through entering operand X, then operand Y and the add/sub mode, from four data switches, one debounced press of Btn0 per step. It drives the registered operands and carry-in into the datapath and captures the 5-bit arithmetic result and the comparator flags. It then holds the captured values stable for the display stage until the next press.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 250000 — consecutive stable cycles required before the debounced button level changes. Legal range is 2 or more.

Ports:
- Clk — in, 1 — system clock. One clock domain only.
- Rst — in, 1 — synchronous, active-high reset.
- Btn0 — in, 1 — raw step button. Asynchronous and bouncy.
- Sw — in, 4 — operand data switches.
- Mode — in, 1 — 0 = add, 1 = subtract. Sampled together with Y.
- OpX, OpY — out, 4 each — registered operands to the adder/subtractor and comparator.
- Cin — out, 1 — registered mode/carry-in to the adder/subtractor.
- Sum — in, 4 — adder/subtractor sum. Combinational from OpX, OpY and Cin.
- Cout — in, 1 — adder/subtractor carry-out.
- Lt, Gt, Eq — in, 1 each — comparator flags for OpX vs OpY.
- Result — out, 5 — captured {Cout, Sum}.
- CompOut — out, 3 — captured {Lt, Gt, Eq}.
- Valid — out, 1 — high while Result and CompOut hold a completed operation.
- State — out, 2 — current state encoding, for debug LEDs.

## Operation
- Button path:
  - Btn0 passes through a 2-flop synchronizer.
  - The synchronized value then goes through the optional debouncer (see Configuration) to produce the level `lvl`.
  - `press` is a one-cycle pulse generated on each 0→1 transition of `lvl`.
- Arm flag:
  - Cleared by reset. Set the first cycle `lvl` is 0.
  - `press` is suppressed while the flag is clear, so a button held through reset never produces a step.
- State machine, encoding on State:
  - ENTER_X (0): on `press`, OpX ← Sw, go to ENTER_Y.
  - ENTER_Y (1): on `press`, OpY ← Sw and Cin ← Mode, go to EXEC.
  - EXEC (2): lasts exactly one cycle, with no condition. Result ← {Cout, Sum}, CompOut ← {Lt, Gt, Eq}, Valid ← 1, go to SHOW.
  - SHOW (3): on `press`, Valid ← 0, go to ENTER_X. OpX, OpY, Cin, Result and CompOut are held.
- Arithmetic is performed by the datapath and is not recomputed here.
  - Add: Result = X + Y, with Cout as the 5th bit.
  - Subtract: Result = {Cout, X + ~Y + 1}. This is the raw 4-bit two's-complement difference with the carry as a no-borrow flag.
- `press` arriving in EXEC is discarded, not queued.
- Sw and Mode changes outside the sampling cycles have no effect on any output.
- Only OpX, OpY, Cin, Result, CompOut, Valid and the state register change in this block. No other output is modified.

## Timing
- Reset values: State=0 (ENTER_X), OpX=0, OpY=0, Cin=0, Result=0, CompOut=0, Valid=0. Synchronizer, debouncer, `lvl` and arm flag are all cleared.
- Reset has priority over every other event in the same cycle, including a coincident `press`. Reset mid-operation in any state returns the block to the values above in the next cycle.
- Btn0 rising to `press` latency:
  - with debounce: 2 cycles synchronizer + DEBOUNCE_CYCLES + 1 cycle edge detect;
  - without: 2 + 1 cycles.
- Operands are registered on the `press` cycle. The datapath settles during the EXEC cycle.
- Result, CompOut and Valid are updated on the EXEC→SHOW edge. They are valid from the first SHOW cycle, 2 cycles after the Y `press`.
- A held button yields exactly one `press`. Another press requires `lvl` to return to 0 first.

## Configuration
- ALU_STEP_DEBOUNCE_EN defined:
  - A counter increments each cycle while the synchronized button differs from `lvl`, and clears whenever they match.
  - When the count reaches DEBOUNCE_CYCLES−1, `lvl` toggles and the counter clears.
- Macro not defined:
  - `lvl` equals the synchronizer output directly and no counter is built.
  - DEBOUNCE_CYCLES is ignored.
  - Intended for simulation and for boards with hardware-debounced buttons.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 with ALU_STEP_DEBOUNCE_EN defined, unless noted.
- Reset: assert Rst for 2 cycles → State=0, OpX=0, OpY=0, Cin=0, Result=0, CompOut=0, Valid=0.
- Add: X=9, then Y=8 with Mode=0 → Cin=0; Valid=1 two cycles after the Y press; Result=5'b10001; CompOut=3'b010.
- Subtract: X=3, then Y=5 with Mode=1 → Cin=1; Result=5'b01110; CompOut=3'b100. Then toggle Sw and Mode during SHOW → Result unchanged. Next press → State=0, Valid=0.
- Bounce, with the datapath stubbed to Sum=0, Cout=0, Lt=0, Gt=0, Eq=1:
  - 2-cycle Btn0 glitches → no state change;
  - Btn0 high for 100 cycles → exactly one advance;
  - macro undefined → advance 3 cycles after Btn0 rises.
- Reset mid-operation, same stubbed datapath: latch X=7, reach ENTER_Y, assert Rst while Btn0 is held high and keep Btn0 high for 20 cycles after reset → State=0, OpX=0, no advance. After release and a re-press → OpX ← Sw.
- Ignored press in EXEC, with Btn0 bypassing the synchronizer:
  - `press` forced in the EXEC cycle → discarded, block still reaches SHOW;
  - Rst coincident with the Y `press` → State=0, OpY=0.

Source files
------------

// File: rtl/alu_step_sequencer_if.sv
// Signal bundle between the step sequencer, the lab-board button/switches and
// the external 4-bit adder/subtractor + comparator datapath.
interface alu_step_sequencer_if;
  logic       Btn0;
  logic [3:0] Sw;
  logic       Mode;
  logic [3:0] OpX;
  logic [3:0] OpY;
  logic       Cin;
  logic [3:0] Sum;
  logic       Cout;
  logic       Lt;
  logic       Gt;
  logic       Eq;
  logic [4:0] Result;
  logic [2:0] CompOut;
  logic       Valid;
  logic [1:0] State;

  // Sequencer side.
  modport master (
    input  Btn0, Sw, Mode, Sum, Cout, Lt, Gt, Eq,
    output OpX, OpY, Cin, Result, CompOut, Valid, State
  );

  // Board / datapath side.
  modport slave (
    output Btn0, Sw, Mode, Sum, Cout, Lt, Gt, Eq,
    input  OpX, OpY, Cin, Result, CompOut, Valid, State
  );
endinterface

// File: rtl/alu_step_sequencer.sv
// Button-stepped operand entry / capture sequencer for the 4-bit ALU lab datapath.
// Define ALU_STEP_DEBOUNCE_EN to build the DEBOUNCE_CYCLES debouncer on Btn0.
module alu_step_sequencer #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input logic                  Clk,
  input logic                  Rst,
  alu_step_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    ENTER_X = 2'd0,
    ENTER_Y = 2'd1,
    EXEC    = 2'd2,
    SHOW    = 2'd3
  } state_t;

  if (DEBOUNCE_CYCLES < 2) begin : g_param_check
    $error("alu_step_sequencer: DEBOUNCE_CYCLES must be 2 or more");
  end

  logic [1:0] sync_reg;
  logic       lvl;
  logic       lvl_d_reg;
  logic       arm_reg;
  logic [1:0] warm_reg;
  logic       press;

  // Arming waits until the synchronizer has refilled with post-reset samples,
  // so a button held through reset is seen as held rather than as a new press.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      sync_reg  <= 2'b00;
      lvl_d_reg <= 1'b0;
      arm_reg   <= 1'b0;
      warm_reg  <= 2'd0;
    end else begin
      sync_reg  <= {sync_reg[0], bus.Btn0};
      lvl_d_reg <= lvl;
      if (warm_reg != 2'd2) begin
        warm_reg <= warm_reg + 2'd1;
      end
      if ((warm_reg == 2'd2) && !sync_reg[1] && !lvl) begin
        arm_reg <= 1'b1;
      end
    end
  end

`ifdef ALU_STEP_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_reg;
  logic          lvl_reg;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt_reg <= '0;
      lvl_reg <= 1'b0;
    end else if (sync_reg[1] == lvl_reg) begin
      cnt_reg <= '0;
    end else if (cnt_reg == CNT_LAST) begin
      cnt_reg <= '0;
      lvl_reg <= ~lvl_reg;
    end else begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  assign lvl = lvl_reg;
`else
  assign lvl = sync_reg[1];
`endif

  assign press = lvl & ~lvl_d_reg & arm_reg;

  state_t     state_reg;
  logic [3:0] opx_reg;
  logic [3:0] opy_reg;
  logic       cin_reg;
  logic [4:0] result_reg;
  logic [2:0] comp_reg;
  logic       valid_reg;

  // EXEC is unconditional, so a press landing there is simply dropped.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg  <= ENTER_X;
      opx_reg    <= 4'd0;
      opy_reg    <= 4'd0;
      cin_reg    <= 1'b0;
      result_reg <= 5'd0;
      comp_reg   <= 3'd0;
      valid_reg  <= 1'b0;
    end else begin
      unique case (state_reg)
        ENTER_X: begin
          if (press) begin
            opx_reg   <= bus.Sw;
            state_reg <= ENTER_Y;
          end
        end
        ENTER_Y: begin
          if (press) begin
            opy_reg   <= bus.Sw;
            cin_reg   <= bus.Mode;
            state_reg <= EXEC;
          end
        end
        EXEC: begin
          result_reg <= {bus.Cout, bus.Sum};
          comp_reg   <= {bus.Lt, bus.Gt, bus.Eq};
          valid_reg  <= 1'b1;
          state_reg  <= SHOW;
        end
        SHOW: begin
          if (press) begin
            valid_reg <= 1'b0;
            state_reg <= ENTER_X;
          end
        end
        default: state_reg <= ENTER_X;
      endcase
    end
  end

  assign bus.OpX     = opx_reg;
  assign bus.OpY     = opy_reg;
  assign bus.Cin     = cin_reg;
  assign bus.Result  = result_reg;
  assign bus.CompOut = comp_reg;
  assign bus.Valid   = valid_reg;
  assign bus.State   = state_reg;

endmodule
